// File: rtl/perf_stat_counter_pkg.sv
// Shared CPU constants for the performance-statistic block: FSM state
// encodings and the stat_out select codes.
package perf_stat_counter_pkg;

  // RUN must encode as 0 so a cleared state register means "running".
  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  localparam int NUM_STATS = 4;

  localparam logic [1:0] SEL_TOTAL  = 2'd0;
  localparam logic [1:0] SEL_BRANCH = 2'd1;
  localparam logic [1:0] SEL_TAKEN  = 2'd2;
  localparam logic [1:0] SEL_JUMP   = 2'd3;

endpackage

// File: rtl/perf_stat_counter_sat_counter.sv
// Saturating up-counter with synchronous clear. Clear wins over inc, and
// the count sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_reg;

  // Clear has priority; otherwise count up until all ones, then hold.
  always_ff @(posedge clk) begin
    if (clear) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + ONE;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/perf_stat_counter.sv
// Run/halt control for the CPU PC plus four saturating event counters
// (cycles, conditional branches, taken branches, jumps) readable via sel.
module perf_stat_counter
  import perf_stat_counter_pkg::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   halt_req,
  input  logic                   is_branch,
  input  logic                   branch_taken,
  input  logic                   is_jump,
  input  logic                   go,
  input  logic [1:0]             sel,
  output logic                   pc_enable,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] stat_out
);

  state_e state_reg;
  state_e state_next;
  logic   go_q_reg;
  logic   go_rise;
  logic   in_run;

  logic [NUM_STATS-1:0]   inc_vec;
  logic [COUNT_WIDTH-1:0] count_arr [NUM_STATS];

  assign in_run  = (state_reg == ST_RUN);
  assign go_rise = go & ~go_q_reg;

  // State and go history; go is sampled every cycle so a held button
  // never produces a second edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_RUN;
      go_q_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      go_q_reg  <= go;
    end
  end

  // Next state: halt_req only matters in RUN, go edges only in HALTED,
  // so a coincident halt_req and go edge in RUN lands in HALTED.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN:    if (halt_req) state_next = ST_HALTED;
      ST_HALTED: if (go_rise)  state_next = ST_RUN;
      default:   state_next = ST_RUN;
    endcase
  end

  // PC freezes on the halting instruction itself, hence the direct halt_req term.
  assign pc_enable = in_run & ~halt_req;
  assign halted    = (state_reg == ST_HALTED);

  // Event qualifiers: nothing is counted while halted.
  always_comb begin
    inc_vec             = '0;
    inc_vec[SEL_TOTAL]  = in_run;
    inc_vec[SEL_BRANCH] = in_run & is_branch;
    inc_vec[SEL_TAKEN]  = in_run & is_branch & branch_taken;
    inc_vec[SEL_JUMP]   = in_run & is_jump;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STATS; gi++) begin : g_stat
      sat_counter #(
        .WIDTH (COUNT_WIDTH)
      ) u_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (inc_vec[gi]),
        .count (count_arr[gi])
      );
    end
  endgenerate

  // Combinational read mux so a sel change is visible in the same cycle.
  always_comb begin
    stat_out = '0;
    case (sel)
      SEL_TOTAL:  stat_out = count_arr[SEL_TOTAL];
      SEL_BRANCH: stat_out = count_arr[SEL_BRANCH];
      SEL_TAKEN:  stat_out = count_arr[SEL_TAKEN];
      SEL_JUMP:   stat_out = count_arr[SEL_JUMP];
      default:    stat_out = '0;
    endcase
  end

endmodule

// File: tb/tb_perf_stat_counter.sv
// Scoreboard bench: stimulus pushes expected values, a negedge monitor pops
// and compares them against the DUT outputs of that cycle.
module tb_perf_stat_counter;

  logic        clk = 1'b0;
  logic        reset, halt_req, is_branch, branch_taken, is_jump, go;
  logic [1:0]  sel;
  logic        pc_enable, halted, pc_enable4, halted4;
  logic [15:0] stat_out;
  logic [3:0]  stat_out4;

  localparam int K_STAT = 0, K_PCEN = 1, K_HALT = 2, K_STAT4 = 3;

  typedef struct {
    string       name;
    int          kind;
    logic [15:0] exp;
  } chk_t;

  chk_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  perf_stat_counter #(.COUNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .halt_req(halt_req), .is_branch(is_branch),
    .branch_taken(branch_taken), .is_jump(is_jump), .go(go), .sel(sel),
    .pc_enable(pc_enable), .halted(halted), .stat_out(stat_out)
  );

  perf_stat_counter #(.COUNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .halt_req(halt_req), .is_branch(is_branch),
    .branch_taken(branch_taken), .is_jump(is_jump), .go(go), .sel(sel),
    .pc_enable(pc_enable4), .halted(halted4), .stat_out(stat_out4)
  );

  task automatic expect_val(input string name, input int kind, input logic [15:0] exp);
    chk_t c;
    c.name = name;
    c.kind = kind;
    c.exp  = exp;
    exp_q.push_back(c);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic events(input logic hr, input logic br, input logic tk, input logic jp);
    halt_req     = hr;
    is_branch    = br;
    branch_taken = tk;
    is_jump      = jp;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Monitor: compare every queued expectation against this cycle's outputs.
  always @(negedge clk) begin : mon
    chk_t        c;
    logic [15:0] act;
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      case (c.kind)
        K_STAT:  act = stat_out;
        K_PCEN:  act = {15'd0, pc_enable};
        K_HALT:  act = {15'd0, halted};
        default: act = {12'd0, stat_out4};
      endcase
      total++;
      if (act !== c.exp) begin
        bad++;
        $display("FAIL %s: got %0d, expected %0d", c.name, act, c.exp);
      end else begin
        $display("check %s: got %0d ok", c.name, act);
      end
    end
  end

  logic [9:0]  br_v, tk_v, jp_v;
  logic [15:0] exp_stat [4];

  initial begin
    reset = 1'b1; sel = 2'd0; go = 1'b0;
    events(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset outputs: pc_enable follows ~halt_req, halted=0, every stat 0.
    step();
    halt_req = 1'b1;
    expect_val("rst_pcen_hr1", K_PCEN, 16'd0);
    expect_val("rst_halted", K_HALT, 16'd0);
    step();
    halt_req = 1'b0;
    expect_val("rst_pcen_hr0", K_PCEN, 16'd1);
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      expect_val($sformatf("rst_sel%0d", s), K_STAT, 16'd0);
      step();
    end

    // Basic counting: 10 RUN edges, the last one also halts to freeze counters.
    br_v = 10'b00_0101_0101;
    tk_v = 10'b00_0001_0001;
    jp_v = 10'b00_0010_1010;
    exp_stat[0] = 16'd10; exp_stat[1] = 16'd4; exp_stat[2] = 16'd2; exp_stat[3] = 16'd3;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      events(i == 9, br_v[i], tk_v[i], jp_v[i]);
      if (i == 9) expect_val("t1_pcen_on_halt", K_PCEN, 16'd0);
      step();
    end
    events(1'b0, 1'b0, 1'b0, 1'b0);
    expect_val("t1_halted", K_HALT, 16'd1);
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      expect_val($sformatf("t1_sel%0d", s), K_STAT, exp_stat[s]);
      step();
    end

    // Halt and resume: halt_req on cycle 5, frozen for 20 cycles, then go.
    sel = 2'd0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      events(i == 4, 1'b0, 1'b0, 1'b0);
      expect_val($sformatf("t2_pcen_c%0d", i + 1), K_PCEN, (i == 4) ? 16'd0 : 16'd1);
      if (i == 4) expect_val("t2_not_yet_halted", K_HALT, 16'd0);
      step();
    end
    expect_val("t2_halted", K_HALT, 16'd1);
    for (int i = 0; i < 20; i++) begin
      events(i[0], 1'b1, 1'b1, 1'b1);
      if (i == 0 || i == 19) begin
        expect_val($sformatf("t2_frozen_%0d", i), K_STAT, 16'd5);
        expect_val($sformatf("t2_pcen_halt_%0d", i), K_PCEN, 16'd0);
      end
      step();
    end
    events(1'b0, 1'b0, 1'b0, 1'b0);
    sel = 2'd1;
    expect_val("t2_branch_frozen", K_STAT, 16'd0);
    step();
    sel = 2'd0;
    go = 1'b1;
    expect_val("t2_go_cycle_halted", K_HALT, 16'd1);
    step();
    go = 1'b0;
    expect_val("t2_resumed", K_HALT, 16'd0);
    expect_val("t2_total_after_go", K_STAT, 16'd5);
    step();
    expect_val("t2_counting_again", K_STAT, 16'd6);
    step();

    // Held go: go high across halt entry gives no edge; a fresh rise held
    // 10 cycles gives one resume; a second halt waits for fall and rise.
    do_reset();
    go = 1'b1;
    step();
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 0 || i == 9) expect_val($sformatf("t3_held_across_%0d", i), K_HALT, 16'd1);
      step();
    end
    go = 1'b0;
    step();
    go = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      if (i == 0 || i == 9) expect_val($sformatf("t3_one_resume_%0d", i), K_HALT, 16'd0);
      step();
    end
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) expect_val("t3_second_halt_held", K_HALT, 16'd1);
      step();
    end
    go = 1'b0;
    step();
    expect_val("t3_still_halted_go_low", K_HALT, 16'd1);
    go = 1'b1;
    step();
    expect_val("t3_second_resume", K_HALT, 16'd0);
    go = 1'b0;

    // Coincident halt_req and go edge in RUN: halt wins.
    do_reset();
    events(1'b1, 1'b0, 1'b0, 1'b0);
    go = 1'b1;
    step();
    halt_req = 1'b0;
    expect_val("t5_coincident_halted", K_HALT, 16'd1);
    step();
    expect_val("t5_still_halted", K_HALT, 16'd1);
    expect_val("t5_total_before_rst", K_STAT, 16'd1);
    go = 1'b0;

    // Reset while HALTED with a nonzero counter: all clear after one edge.
    reset = 1'b1;
    step();
    expect_val("t6_halted_cleared", K_HALT, 16'd0);
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      expect_val($sformatf("t6_sel%0d", s), K_STAT, 16'd0);
      step();
    end
    reset = 1'b0;

    // Saturation on the 4-bit instance: 20 branch cycles hold at 15.
    sel = 2'd0;
    events(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (i == 15) expect_val("t4_sat_reached", K_STAT4, 16'd15);
      step();
    end
    expect_val("t4_sat_total", K_STAT4, 16'd15);
    expect_val("t4_wide_total", K_STAT, 16'd20);
    step();
    expect_val("t4_sat_stays", K_STAT4, 16'd15);
    sel = 2'd1;
    expect_val("t4_sat_branch", K_STAT4, 16'd15);
    step();
    events(1'b0, 1'b0, 1'b0, 1'b0);
    step();

    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
